multicycle_main_fsm: RTL and testbench

Main control state machine for the multicycle variant of the processor. Sequences each instruction through fetch, decode, execute, memory and writeback steps, drives the datapath mux selects, and produces the unqualified RegW, MemW and Branch strobes. Conditional_Logic consumes these strobes and gates them with CondEx. Sits directly upstream of the conditional logic, beside the ALU decoder, which consumes ALUOp.

---
 rtl/multicycle_main_fsm.sv | 80 ++++++++
 tb/tb_multicycle_main_fsm.sv | 128 ++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: multicycle instruction sequencer driving datapath selects and unqualified strobes.
// Define MULTICYCLE_BL_EN to enable branch-with-link (LinkW/RegW in BRANCH when Funct[4]=1).
module multicycle_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       LinkW,
    output logic       Illegal,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_e;

    state_e state_q, state_d;
    logic   unused_funct;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = MemReady ? DECODE : FETCH;
            DECODE:   state_d = Op == 2'b01 ? MEMADR :
                                Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                Op == 2'b10 ? BRANCH : FETCH;
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
            MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Strobes are qualified by reset so nothing fires while it is held low.
    assign IRWrite   = reset && state_q == FETCH && MemReady;
    assign NextPC    = IRWrite;
    assign AdrSrc    = state_q == MEMREAD || state_q == MEMWRITE;
    assign ALUSrcA   = state_q == FETCH || state_q == DECODE;
    assign ALUSrcB   = (state_q == FETCH || state_q == DECODE) ? 2'b10 :
                       (state_q == MEMADR || state_q == EXECUTEI || state_q == BRANCH) ? 2'b01 : 2'b00;
    assign ResultSrc = (state_q == FETCH || state_q == DECODE || state_q == BRANCH) ? 2'b10 :
                       state_q == MEMWB ? 2'b01 : 2'b00;
    assign ALUOp     = state_q == EXECUTER || state_q == EXECUTEI;
`ifdef MULTICYCLE_BL_EN
    assign LinkW     = reset && state_q == BRANCH && Funct[4];
`else
    assign LinkW     = 1'b0;
`endif
    assign RegW      = reset && (state_q == MEMWB || state_q == ALUWB || LinkW);
    assign MemW      = reset && state_q == MEMWRITE;
    assign Branch    = reset && state_q == BRANCH;
    assign Illegal   = reset && state_q == DECODE && Op == 2'b11;
    assign State     = state_q;
    assign unused_funct = ^Funct[4:1];
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed sequences with a queued scoreboard checked once per cycle on the falling edge.
module tb_multicycle_main_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       MemReady = 1'b1;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, LinkW, Illegal;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    multicycle_main_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .LinkW(LinkW), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    // {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, LinkW, Illegal}
    localparam logic [17:0] E_RST  = 18'b0000_0_0_0_1_10_10_0_0_0_0_0_0;
    localparam logic [17:0] E_F0   = 18'b0000_0_0_0_1_10_10_0_0_0_0_0_0;
    localparam logic [17:0] E_F1   = 18'b0000_1_1_0_1_10_10_0_0_0_0_0_0;
    localparam logic [17:0] E_DEC  = 18'b0001_0_0_0_1_10_10_0_0_0_0_0_0;
    localparam logic [17:0] E_ILL  = 18'b0001_0_0_0_1_10_10_0_0_0_0_0_1;
    localparam logic [17:0] E_MADR = 18'b0010_0_0_0_0_01_00_0_0_0_0_0_0;
    localparam logic [17:0] E_MRD  = 18'b0011_0_0_1_0_00_00_0_0_0_0_0_0;
    localparam logic [17:0] E_MWB  = 18'b0100_0_0_0_0_00_01_0_1_0_0_0_0;
    localparam logic [17:0] E_MWR  = 18'b0101_0_0_1_0_00_00_0_0_1_0_0_0;
    localparam logic [17:0] E_EXR  = 18'b0110_0_0_0_0_00_00_1_0_0_0_0_0;
    localparam logic [17:0] E_EXI  = 18'b0111_0_0_0_0_01_00_1_0_0_0_0_0;
    localparam logic [17:0] E_AWB  = 18'b1000_0_0_0_0_00_00_0_1_0_0_0_0;
`ifdef MULTICYCLE_BL_EN
    localparam logic [17:0] E_BL   = 18'b1001_0_0_0_0_01_10_0_1_0_1_1_0;
`else
    localparam logic [17:0] E_BL   = 18'b1001_0_0_0_0_01_10_0_0_0_1_0_0;
`endif

    typedef struct {
        string       nm;
        logic [17:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic step(input string nm, input logic rst, input logic [1:0] op,
                        input logic [5:0] fn, input logic mr, input logic [17:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        Op = op;
        Funct = fn;
        MemReady = mr;
        e.nm = nm;
        e.v = v;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [17:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                   ALUOp, RegW, MemW, Branch, LinkW, Illegal};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s actual=%b expected=%b", e.nm, act, e.v);
            end
        end
    end

    initial begin
        step("rst_hold0", 1'b0, 2'b00, 6'b000000, 1'b1, E_RST);
        step("rst_hold1", 1'b0, 2'b00, 6'b000000, 1'b1, E_RST);
        step("dpr_fetch", 1'b1, 2'b00, 6'b000000, 1'b1, E_F1);
        step("dpr_dec",   1'b1, 2'b00, 6'b000000, 1'b1, E_DEC);
        step("dpr_exec",  1'b1, 2'b00, 6'b000000, 1'b1, E_EXR);
        step("dpr_wb",    1'b1, 2'b00, 6'b000000, 1'b1, E_AWB);
        step("dpi_fetch", 1'b1, 2'b00, 6'b100000, 1'b1, E_F1);
        step("dpi_dec",   1'b1, 2'b00, 6'b100000, 1'b1, E_DEC);
        step("dpi_exec",  1'b1, 2'b00, 6'b100000, 1'b1, E_EXI);
        step("dpi_wb",    1'b1, 2'b00, 6'b100000, 1'b1, E_AWB);
        step("ld_fetch",  1'b1, 2'b01, 6'b000001, 1'b1, E_F1);
        step("ld_dec",    1'b1, 2'b01, 6'b000001, 1'b1, E_DEC);
        step("ld_adr",    1'b1, 2'b01, 6'b000001, 1'b0, E_MADR);
        step("ld_wait0",  1'b1, 2'b01, 6'b000001, 1'b0, E_MRD);
        step("ld_wait1",  1'b1, 2'b01, 6'b000001, 1'b0, E_MRD);
        step("ld_read",   1'b1, 2'b01, 6'b000001, 1'b1, E_MRD);
        step("ld_wb",     1'b1, 2'b01, 6'b000001, 1'b1, E_MWB);
        step("st_fetch",  1'b1, 2'b01, 6'b000000, 1'b1, E_F1);
        step("st_dec",    1'b1, 2'b01, 6'b000000, 1'b1, E_DEC);
        step("st_adr",    1'b1, 2'b01, 6'b000000, 1'b1, E_MADR);
        step("st_write",  1'b1, 2'b01, 6'b000000, 1'b1, E_MWR);
        step("bl_fetch",  1'b1, 2'b10, 6'b010000, 1'b1, E_F1);
        step("bl_dec",    1'b1, 2'b10, 6'b010000, 1'b1, E_DEC);
        step("bl_branch", 1'b1, 2'b10, 6'b010000, 1'b1, E_BL);
        step("ill_fetch", 1'b1, 2'b11, 6'b000000, 1'b1, E_F1);
        step("ill_dec",   1'b1, 2'b11, 6'b000000, 1'b1, E_ILL);
        step("fw_wait0",  1'b1, 2'b11, 6'b000000, 1'b0, E_F0);
        step("fw_wait1",  1'b1, 2'b11, 6'b000000, 1'b0, E_F0);
        step("fw_wait2",  1'b1, 2'b11, 6'b000000, 1'b0, E_F0);
        step("fw_ready",  1'b1, 2'b01, 6'b000000, 1'b1, E_F1);
        step("sw_dec",    1'b1, 2'b01, 6'b000000, 1'b1, E_DEC);
        step("sw_adr",    1'b1, 2'b01, 6'b000000, 1'b0, E_MADR);
        step("sw_wait0",  1'b1, 2'b01, 6'b000000, 1'b0, E_MWR);
        step("sw_wait1",  1'b1, 2'b01, 6'b000000, 1'b1, E_MWR);
        step("rst_midwr", 1'b0, 2'b01, 6'b000000, 1'b1, E_RST);
        step("rst_low",   1'b0, 2'b01, 6'b000000, 1'b1, E_RST);
        step("rl_fetch",  1'b1, 2'b00, 6'b000000, 1'b1, E_F1);
        step("rl_dec",    1'b1, 2'b00, 6'b000000, 1'b1, E_DEC);
        step("rl_exec",   1'b1, 2'b00, 6'b000000, 1'b1, E_EXR);
        step("rl_wb",     1'b1, 2'b00, 6'b000000, 1'b1, E_AWB);
        step("rl_next",   1'b1, 2'b00, 6'b000000, 1'b1, E_F1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
